// File: rtl/seq_divider.sv
// seq_divider
//   Sequential unsigned restoring divider (shift-subtract). Each quotient bit
//   takes two states: one shift and one subtract.
//   The dividend is entered on S with LoadDividend. Run then latches S as the
//   divisor and starts the division.
//
// Ports
//   Clk          system clock; all state changes on the rising edge
//   Reset        synchronous, active-high reset; aborts any division
//   LoadDividend level; in ready, loads S into the quotient/dividend register
//   Run          level; in ready, starts a division with S as the divisor
//   S            switch input: dividend on load, divisor on start
//   Qval         quotient register
//   Rval         remainder register
//   Busy         high in start, shift and sub
//   Done         high in done
//   DivByZero    sticky error flag for the current result
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_READY | idle; Run starts a division, LoadDividend loads the dividend
// ST_LOAD  | Q <= S, clears R and DivByZero
// ST_START | latch divisor, clear count; a zero divisor goes straight to done
// ST_SHIFT | {R,Q} shifted left one place, carry out of R kept in rx
// ST_SUB   | trial subtract of the divisor, sets the quotient LSB
// ST_DONE  | result held until Run is released

module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadDividend,
    input  logic             Run,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_READY,
        ST_LOAD,
        ST_START,
        ST_SHIFT,
        ST_SUB,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] q, r, d;
    logic [CW-1:0]    c;
    logic             rx;
    logic             dbz;

    // Trial value {carry, R}. R < D before the shift, so the trial is below
    // 2D and the difference always fits back into WIDTH bits.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff_lo;
    logic             fits;

    assign trial   = {rx, r};
    assign fits    = (trial >= {1'b0, d});
    assign diff_lo = r - d;   // modular low bits equal the true difference when fits

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_READY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            ST_READY: begin
                if (Run)
                    state_nxt = ST_START;
                else if (LoadDividend)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_READY;
            end
            ST_START: begin
                Busy      = 1'b1;
                state_nxt = (S == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                Busy      = 1'b1;
                state_nxt = ST_SUB;
            end
            ST_SUB: begin
                Busy      = 1'b1;
                state_nxt = (c == LAST) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                Done = 1'b1;
                if (!Run)
                    state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_READY;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            c   <= '0;
            rx  <= 1'b0;
            dbz <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    q   <= S;
                    r   <= '0;
                    rx  <= 1'b0;
                    dbz <= 1'b0;
                end
                ST_START: begin
                    d  <= S;
                    c  <= '0;
                    rx <= 1'b0;
                    if (S == '0) begin
                        // Report the dividend as the remainder.
                        q   <= '1;
                        r   <= q;
                        dbz <= 1'b1;
                    end else begin
                        r   <= '0;
                        dbz <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    rx <= r[WIDTH-1];
                    r  <= {r[WIDTH-2:0], q[WIDTH-1]};
                    q  <= {q[WIDTH-2:0], 1'b0};
                end
                ST_SUB: begin
                    if (fits) begin
                        r    <= diff_lo;
                        q[0] <= 1'b1;
                    end else begin
                        q[0] <= 1'b0;
                    end
                    rx <= 1'b0;
                    c  <= c + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Qval      = q;
    assign Rval      = r;
    assign DivByZero = dbz;

endmodule
